// File: rtl/tick_countdown_timer_if.sv
// Control and status bundle between a timer client and tick_countdown_timer.
// Controls are sampled on the rising clk edge; all status fields are registered.
interface tick_countdown_timer_if #(parameter int WIDTH = 8);
  logic             tick;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] remaining;
  logic             busy;
  logic             expired;

  modport master (
    output tick, start, stop, pause, auto_reload, load_val,
    input  remaining, busy, expired
  );

  modport slave (
    input  tick, start, stop, pause, auto_reload, load_val,
    output remaining, busy, expired
  );
endinterface

// File: rtl/tick_countdown_timer.sv
// Tick-driven countdown timer with one-shot/periodic modes, pause and abort.
// Per-cycle input priority: stop, start, pause, tick.
module tick_countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  tick_countdown_timer_if.slave  bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             reload_q, reload_d;
  logic             expired_q, expired_d;
  logic             busy_q;
  logic             abort, do_start, load_zero, run_tick, term_tick;

  // stop only acts on an active count; in IDLE it falls through to start
  assign abort     = bus.stop && (state_q != IDLE);
  assign do_start  = bus.start && !abort;
  assign load_zero = (bus.load_val == '0);
  assign run_tick  = !abort && !bus.start && (state_q == RUN) && !bus.pause && bus.tick;
  assign term_tick = run_tick && (rem_q == WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else if (do_start) begin
      if (load_zero)      state_d = IDLE;
      else if (bus.pause) state_d = PAUSE;
      else                state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.pause)                  state_d = PAUSE;
          else if (term_tick && !reload_q) state_d = IDLE;
        end
        PAUSE:   if (!bus.pause) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rem_d     = rem_q;
    len_d     = len_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (do_start) begin
      if (load_zero) begin
        rem_d     = '0;
        expired_d = 1'b1;
      end else begin
        rem_d    = bus.load_val;
        len_d    = bus.load_val;
        reload_d = bus.auto_reload;
      end
    end else if (term_tick) begin
      expired_d = 1'b1;
      rem_d     = reload_q ? len_q : '0;
    end else if (run_tick && (rem_q > WIDTH'(1))) begin
      rem_d = rem_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      len_q     <= '0;
      reload_q  <= 1'b0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      len_q     <= len_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.remaining = rem_q;
  assign bus.expired   = expired_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Self-checking bench for tick_countdown_timer: directed scenarios plus a
// randomized run compared every cycle against a behavioural timer model.
module tb_tick_countdown_timer;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  tick_countdown_timer_if #(.WIDTH(W)) bus ();

  tick_countdown_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  // behavioural model: an active count is either counting or frozen
  bit         m_active, m_frozen, m_periodic, m_exp;
  int         m_left, m_period;

  function automatic void model_reset();
    m_active = 0; m_frozen = 0; m_periodic = 0; m_exp = 0;
    m_left = 0; m_period = 0;
  endfunction

  function automatic void model_step(bit st, bit sp, bit ps, bit tk, bit ar, int lv);
    bit fire = 0;
    if (sp && m_active) begin
      m_active = 0; m_frozen = 0;
    end else if (st) begin
      if (lv == 0) begin
        m_left = 0; m_active = 0; m_frozen = 0; fire = 1;
      end else begin
        m_left = lv; m_period = lv; m_periodic = ar; m_active = 1; m_frozen = ps;
      end
    end else if (m_active && m_frozen) begin
      if (!ps) m_frozen = 0;
    end else if (m_active) begin
      if (ps) m_frozen = 1;
      else if (tk) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          fire = 1;
          if (m_periodic) m_left = m_period;
          else m_active = 0;
        end
      end
    end
    m_exp = fire;
  endfunction

  // driver: apply inputs for one clock, update model at the edge, settle 1ns
  task automatic cyc(input bit st, input bit sp, input bit ps, input bit tk,
                     input bit ar, input logic [W-1:0] lv);
    bus.start = st; bus.stop = sp; bus.pause = ps; bus.tick = tk;
    bus.auto_reload = ar; bus.load_val = lv;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step(st, sp, ps, tk, ar, int'(lv));
    #1;
    bus.start = 0; bus.stop = 0; bus.tick = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.tick = 0;
    bus.auto_reload = 0; bus.load_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tests_run++;
    if ({bus.remaining, bus.busy, bus.expired, dbg_state} !== {8'd0, 1'b0, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_state rem=%0d busy=%0b exp=%0b st=%0d want 0/0/0/0",
               bus.remaining, bus.busy, bus.expired, dbg_state);
    end
    // ticks and stop in IDLE do nothing
    for (int i = 0; i < 4; i++) cyc(0, i[0], 0, 1, 0, '0);
    tests_run++;
    if ({bus.remaining, bus.busy, bus.expired} !== {8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL idle_ticks rem=%0d busy=%0b exp=%0b want 0/0/0",
               bus.remaining, bus.busy, bus.expired);
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] want;
    exp_q = {8'd3, 8'd2, 8'd1, 8'd0};
    cyc(1, 0, 0, 0, 0, 8'd3);
    want = exp_q.pop_front();
    tests_run++;
    if (bus.remaining !== want || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL one_shot_load rem=%0d busy=%0b want %0d/1", bus.remaining, bus.busy, want);
    end
    for (int t = 1; t <= 3; t++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(0, 0, 0, 0, 0, '0);
        tests_run++;
        if (bus.expired !== 1'b0) begin
          tests_failed++;
          $display("FAIL one_shot_gap exp=%0b want 0", bus.expired);
        end
      end
      cyc(0, 0, 0, 1, 0, '0);
      want = exp_q.pop_front();
      tests_run++;
      if ({bus.remaining, bus.expired, bus.busy} !== {want, (t == 3), (t != 3)}) begin
        tests_failed++;
        $display("FAIL one_shot_tick%0d rem=%0d exp=%0b busy=%0b want %0d/%0b/%0b",
                 t, bus.remaining, bus.expired, bus.busy, want, (t == 3), (t != 3));
      end
    end
    idle(1);
    tests_run++;
    if (bus.expired !== 1'b0 || bus.remaining !== 8'd0) begin
      tests_failed++;
      $display("FAIL one_shot_after exp=%0b rem=%0d want 0/0", bus.expired, bus.remaining);
    end
  endtask

  task automatic test_periodic();
    cyc(1, 0, 0, 0, 1, 8'd2);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 0, 0, 1, 0, '0);
      tests_run++;
      if ({bus.remaining, bus.expired, bus.busy} !== {((k % 2 == 0) ? 8'd2 : 8'd1), (k % 2 == 0), 1'b1}) begin
        tests_failed++;
        $display("FAIL periodic_tick%0d rem=%0d exp=%0b busy=%0b", k,
                 bus.remaining, bus.expired, bus.busy);
      end
    end
    cyc(0, 1, 0, 0, 0, '0);
  endtask

  task automatic test_pause();
    cyc(1, 0, 0, 0, 0, 8'd4);
    cyc(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, (i == 2 || i == 5 || i == 8), 0, '0);
      tests_run++;
      if (bus.remaining !== 8'd3 || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL pause_hold%0d rem=%0d busy=%0b want 3/1", i, bus.remaining, bus.busy);
      end
    end
    cyc(0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, '0);
    tests_run++;
    if (bus.remaining !== 8'd2) begin
      tests_failed++;
      $display("FAIL pause_resume rem=%0d want 2", bus.remaining);
    end
    cyc(1, 0, 0, 1, 0, 8'd6);
    tests_run++;
    if (bus.remaining !== 8'd6) begin
      tests_failed++;
      $display("FAIL start_with_tick rem=%0d want 6", bus.remaining);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, 0, 0, 8'd5);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(1, 0, 0, 1, 1, 8'd2);
    tests_run++;
    if ({bus.remaining, bus.expired, bus.busy} !== {8'd2, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL restart rem=%0d exp=%0b busy=%0b want 2/0/1",
               bus.remaining, bus.expired, bus.busy);
    end
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 1, 0, '0);
    tests_run++;
    if ({bus.remaining, bus.expired, bus.busy} !== {8'd2, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL restart_mode rem=%0d exp=%0b busy=%0b want 2/1/1",
               bus.remaining, bus.expired, bus.busy);
    end
    cyc(0, 1, 0, 0, 0, '0);
  endtask

  task automatic test_stop_vs_expiry();
    cyc(1, 0, 0, 0, 0, 8'd2);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 1, 0, 1, 0, '0);
    tests_run++;
    if ({bus.remaining, bus.expired, bus.busy, dbg_state} !== {8'd1, 1'b0, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL stop_tick rem=%0d exp=%0b busy=%0b st=%0d want 1/0/0/0",
               bus.remaining, bus.expired, bus.busy, dbg_state);
    end
    idle(2);
    tests_run++;
    if (bus.expired !== 1'b0 || bus.remaining !== 8'd1) begin
      tests_failed++;
      $display("FAIL stop_after exp=%0b rem=%0d want 0/1", bus.expired, bus.remaining);
    end
    cyc(1, 0, 0, 0, 0, 8'd0);
    tests_run++;
    if ({bus.remaining, bus.expired, bus.busy} !== {8'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL zero_load rem=%0d exp=%0b busy=%0b want 0/1/0",
               bus.remaining, bus.expired, bus.busy);
    end
    idle(1);
    tests_run++;
    if (bus.expired !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_load_after exp=%0b busy=%0b want 0/0", bus.expired, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 0, 0, 8'd7);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 1, 0, '0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({bus.remaining, bus.busy, bus.expired} !== {8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset rem=%0d busy=%0b exp=%0b want 0/0/0",
               bus.remaining, bus.busy, bus.expired);
    end
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0, '0);
      tests_run++;
      if ({bus.remaining, bus.busy, bus.expired} !== {8'd0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL post_reset%0d rem=%0d busy=%0b exp=%0b want 0/0/0",
                 i, bus.remaining, bus.busy, bus.expired);
      end
    end
  endtask

  task automatic test_max_load();
    int fires = 0;
    cyc(1, 0, 0, 0, 0, 8'd255);
    for (int i = 1; i <= 255; i++) begin
      cyc(0, 0, 0, 1, 0, '0);
      if (bus.expired === 1'b1) fires++;
      tests_run++;
      if (bus.remaining !== W'(255 - i)) begin
        tests_failed++;
        $display("FAIL max_count%0d rem=%0d want %0d", i, bus.remaining, 255 - i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, '0);
      if (bus.expired === 1'b1) fires++;
    end
    tests_run++;
    if (fires != 1 || bus.remaining !== 8'd0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_expiry fires=%0d rem=%0d busy=%0b want 1/0/0",
               fires, bus.remaining, bus.busy);
    end
  endtask

  task automatic test_random();
    bit ps = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ps = ~ps;
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, ps,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 5)));
      tests_run++;
      if ({bus.remaining, bus.busy, bus.expired} !== {W'(m_left), m_active, m_exp}) begin
        tests_failed++;
        $display("FAIL random%0d rem=%0d busy=%0b exp=%0b want %0d/%0b/%0b",
                 i, bus.remaining, bus.busy, bus.expired, m_left, m_active, m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause();
    test_back_to_back();
    test_stop_vs_expiry();
    test_async_reset();
    test_max_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
